// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction-memory, redirect and decode-side signals of the fetch unit.
// master = fetch unit, slave = memory/decode environment.
interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    modport master (
        output imem_req, imem_addr, out_valid, out_instr, out_pc,
        input  imem_ack, imem_rdata, redirect_valid, redirect_pc, out_ready
    );
    modport slave (
        input  imem_req, imem_addr, out_valid, out_instr, out_pc,
        output imem_ack, imem_rdata, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding prefetcher feeding a small in-order queue, flushed on redirect.
// Define INSTR_FETCH_PERF_CNT_EN to add the perf_fetched/perf_flushed counters.
module instr_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_3000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
`ifdef INSTR_FETCH_PERF_CNT_EN
    ,
    output logic [31:0]   perf_fetched,
    output logic [31:0]   perf_flushed
`endif
);
    localparam int AW = $clog2(QUEUE_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, WAIT_DISCARD} state_t;

    state_t        state, state_n;
    logic [31:0]   fpc, fpc_n, addr_q;
    logic [31:0]   pc_q    [QUEUE_DEPTH];
    logic [31:0]   instr_q [QUEUE_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   cnt, cnt_n;
    logic          ack, push, pop, drop, issue;

    // acks seen while nothing is outstanding (e.g. right after reset) are ignored
    assign ack  = bus.imem_ack && state != IDLE;
    assign push = ack && state == WAIT && !bus.redirect_valid;
    assign drop = ack && !push;
    assign pop  = bus.out_valid && bus.out_ready;

    assign bus.imem_req  = state != IDLE;
    assign bus.imem_addr = addr_q;
    assign bus.out_valid = cnt != '0;
    assign bus.out_instr = instr_q[rd_ptr];
    assign bus.out_pc    = pc_q[rd_ptr];

    // a new request goes out whenever the slot is free and the queue will still have room for it
    always_comb begin
        cnt_n   = bus.redirect_valid ? '0 : cnt + (AW+1)'(push) - (AW+1)'(pop);
        fpc_n   = bus.redirect_valid ? bus.redirect_pc & ~32'd3 : push ? addr_q + 32'd4 : fpc;
        issue   = (state == IDLE || ack) && cnt_n < (AW+1)'(QUEUE_DEPTH);
        state_n = issue ? WAIT :
                  ack ? IDLE :
                  (state == WAIT && bus.redirect_valid) ? WAIT_DISCARD : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc    <= RESET_PC;
            addr_q <= RESET_PC;
            cnt    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
        end else begin
            fpc <= fpc_n;
            cnt <= cnt_n;
            if (issue)
                addr_q <= fpc_n;
            if (bus.redirect_valid) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    pc_q[wr_ptr]    <= addr_q;
                    instr_q[wr_ptr] <= bus.imem_rdata;
                    wr_ptr          <= wr_ptr + AW'(1);
                end
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

`ifdef INSTR_FETCH_PERF_CNT_EN
    // flushed entries exclude the head accepted in the redirect cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            perf_fetched <= perf_fetched + 32'(push);
            perf_flushed <= perf_flushed + 32'(drop) +
                            (bus.redirect_valid ? 32'(cnt - (AW+1)'(pop)) : 32'd0);
        end
    end
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized bench; expected words are sequential runs from each reset/redirect target.
// A monitor pops the scoreboard on every out handshake; entries of superseded runs are skipped.
module tb_instr_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam int SEG = 300;

    typedef struct {
        int          ep;
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    instr_fetch_if bus();
`ifdef INSTR_FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_flushed;
    logic [31:0] p0;
`endif

    instr_fetch #(.RESET_PC(RESET_PC), .QUEUE_DEPTH(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
`ifdef INSTR_FETCH_PERF_CNT_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_flushed(perf_flushed)
`endif
    );

    always #5 clk = ~clk;

    exp_t        sb[$];
    int          n_cmp = 0, n_fail = 0, n_hs = 0;
    int          ep_w = 0, mon_ep = 0;
    int          lat_mode = 0;
    bit          inject = 1'b0;
    bit          prev_redir = 1'b0;
    bit          busy = 1'b0;
    int          wcnt = 0, n_issued = 0, since = 0;
    logic [31:0] req_addr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E37_79B9 ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic new_seg(input logic [31:0] t);
        logic [31:0] a;
        a = t & ~32'd3;
        ep_w++;
        for (int k = 0; k < SEG; k++) begin
            sb.push_back('{ep_w, a, mem_word(a)});
            a += 32'd4;
        end
    endtask

    // called at posedge+2; returns at the following posedge+2 with the pulse removed
    task automatic redirect(input logic [31:0] t);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = t;
        new_seg(t);
        @(posedge clk); #2;
        bus.redirect_valid = 1'b0;
    endtask

    // called away from a clock edge; returns at the negedge where rst_n is released
    task automatic do_reset(input bit stale, input logic rdy);
        rst_n         = 1'b0;
        inject        = stale;
        bus.out_ready = rdy;
        new_seg(RESET_PC);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_addr", bus.imem_addr, RESET_PC);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_instr", bus.out_instr, 32'd0);
        chk("rst_pc", bus.out_pc, 32'd0);
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid) return;
        end
        n_cmp++;
        n_fail++;
        $display("FAIL %s: out_valid still 0 after 40 cycles", name);
    endtask

    // memory model: random or fixed latency, checks request stability and alignment
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            busy           = 1'b0;
            n_issued       = 0;
            bus.imem_ack   = inject;
            bus.imem_rdata = 32'hDEAD_BEEF;
        end else begin
            if (bus.imem_ack) busy = 1'b0;
            bus.imem_ack = 1'b0;
            if (bus.imem_req) begin
                if (!busy) begin
                    busy     = 1'b1;
                    n_issued++;
                    req_addr = bus.imem_addr;
                    wcnt     = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
                    chk("addr_align", req_addr & 32'd3, 32'd0);
                end else begin
                    chk("req_hold", bus.imem_addr, req_addr);
                end
                if (wcnt == 0) begin
                    bus.imem_ack   = 1'b1;
                    bus.imem_rdata = mem_word(req_addr);
                end else begin
                    wcnt--;
                end
            end else if (busy) begin
                chk("req_drop", 32'(bus.imem_req), 32'd1);
            end
        end
    end

    // monitor: a handshake in a redirect cycle still belongs to the old run
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (prev_redir) chk("flush_valid", 32'(bus.out_valid), 32'd0);
            if (bus.out_valid && bus.out_ready) begin
                n_hs++;
                while (sb.size() > 0 && sb[0].ep < mon_ep) void'(sb.pop_front());
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL sb_empty: got pc %h with nothing expected", bus.out_pc);
                end else begin
                    e = sb.pop_front();
                    chk("out_pc", bus.out_pc, e.pc);
                    chk("out_instr", bus.out_instr, e.instr);
                end
            end
        end
        if (!rst_n || bus.redirect_valid) mon_ep = ep_w;
        prev_redir = rst_n && bus.redirect_valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        bit found;
        logic [31:0] t;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.out_ready      = 1'b1;
        // reset release, zero-wait streaming
        lat_mode = 0;
        do_reset(1'b0, 1'b1);
        @(negedge clk); chk("lat1_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk); chk("lat2_valid", 32'(bus.out_valid), 32'd1);
        chk("seq0", bus.out_pc, 32'h3000);
        @(negedge clk); chk("seq1", bus.out_pc, 32'h3004);
        @(negedge clk); chk("seq2", bus.out_pc, 32'h3008);
        // decode stalled: queue fills with two words, then fetch stops
        do_reset(1'b0, 1'b0);
        repeat (10) @(negedge clk);
        chk("stall_req", 32'(bus.imem_req), 32'd0);
        chk("stall_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_head", bus.out_pc, 32'h3000);
        chk("stall_fetches", 32'(n_issued), 32'd2);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); chk("resume_nogap", 32'(bus.out_valid), 32'd1);
        end
        // redirect while 0x3008 is outstanding on slow memory
        lat_mode = 2;
        do_reset(1'b0, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(posedge clk); #2;
            found = bus.imem_req && bus.imem_addr == 32'h3008 && !bus.imem_ack;
        end
        chk("wait_3008", 32'(found), 32'd1);
        redirect(32'h3402);
        @(negedge clk); chk("redir_flush", 32'(bus.out_valid), 32'd0);
        wait_valid("redir_3400");
        chk("redir_first", bus.out_pc, 32'h3400);
        // redirect coinciding with an ack
        lat_mode = 0;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(posedge clk); #2;
            found = bus.imem_ack && bus.out_valid;
        end
        chk("wait_ack", 32'(found), 32'd1);
`ifdef INSTR_FETCH_PERF_CNT_EN
        p0 = perf_flushed;
`endif
        redirect(32'h5000);
        chk("ack_redir_req", 32'(bus.imem_req), 32'd1);
        chk("ack_redir_addr", bus.imem_addr, 32'h5000);
`ifdef INSTR_FETCH_PERF_CNT_EN
        chk("perf_flushed_delta", perf_flushed - p0, 32'd1);
`endif
        // back-to-back redirects: the last target wins
        redirect(32'h6000);
        redirect(32'h7000);
        wait_valid("b2b");
        chk("b2b_first", bus.out_pc, 32'h7000);
        // reset mid-request, stale ack after release
        lat_mode = 2;
        @(posedge clk); #2;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk); #2;
            found = bus.imem_req && !bus.imem_ack;
        end
        chk("wait_midreq", 32'(found), 32'd1);
        do_reset(1'b1, 1'b1);
        wait_valid("stale");
        chk("stale_pc", bus.out_pc, 32'h3000);
        chk("stale_instr", bus.out_instr, mem_word(32'h3000));
        // wrap at the top of the address space
        lat_mode = 0;
        @(posedge clk); #2;
        redirect(32'hFFFF_FFFC);
        wait_valid("wrap");
        chk("wrap_first", bus.out_pc, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("wrap_valid", 32'(bus.out_valid), 32'd1);
        chk("wrap_second", bus.out_pc, 32'h0000_0000);
        // randomized traffic
        @(posedge clk); #2;
        lat_mode = -1;
        since    = 0;
        for (int c = 0; c < 2000; c++) begin
            bus.out_ready = $urandom_range(0, 9) < 7;
            if (since >= 250 || $urandom_range(0, 19) == 0) begin
                t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
                redirect(t);
                since = 0;
            end else if ($urandom_range(0, 499) == 0) begin
                do_reset(1'($urandom_range(0, 1)), 1'b1);
                @(posedge clk); #2;
                since = 0;
            end else begin
                @(posedge clk); #2;
                since++;
            end
        end
        bus.out_ready = 1'b1;
        repeat (20) @(posedge clk);
        chk("throughput", 32'(n_hs >= 300), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
